// File: rtl/alu_muldiv_iter.sv
// Iterative MIPS mult/multu/div/divu plus HI/LO moves; HI/LO live here.
// Latency: mult/div ITER+2 cycles from accept (ITER = WIDTH/UNROLL); moves and div-by-zero 1 cycle.
// Backpressure: in_ready drops for the whole CALC/FIX window, stalling any issue including mfhi/mflo.
module alu_muldiv_iter #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER = WIDTH / UNROLL;
    localparam int CW   = $clog2(ITER) + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;

    logic [5:0]       funct;
    logic             op_zero;
    logic             is_mul;
    logic             is_div;
    logic             is_signed;
    logic [WIDTH-1:0] rs_op;
    logic [WIDTH-1:0] rt_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    assign funct     = instruction[5:0];
    assign op_zero   = (instruction[31:26] == 6'd0);
    assign is_mul    = op_zero && (funct == F_MULT || funct == F_MULTU);
    assign is_div    = op_zero && (funct == F_DIV || funct == F_DIVU);
    assign is_signed = ~funct[0];
    assign rs_op     = instruction[21] ? regB : regA;
    assign rt_op     = instruction[16] ? regB : regA;

    // Iterate on magnitudes; signs are reapplied in FIX.
    assign a_neg = is_signed & rs_op[WIDTH-1];
    assign b_neg = is_signed & rt_op[WIDTH-1];
    assign a_mag = a_neg ? -rs_op : rs_op;
    assign b_mag = b_neg ? -rt_op : rt_op;

    logic [WIDTH-1:0] nh;
    logic [WIDTH-1:0] nl;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   sum;

    // mult: {acc_hi,acc_lo} shifts right with multiplier bits consumed from acc_lo.
    // div:  acc_hi is the partial remainder, acc_lo collects quotient bits.
    always_comb begin
        nh      = acc_hi;
        nl      = acc_lo;
        shifted = '0;
        diff    = '0;
        sum     = '0;
        for (int u = 0; u < UNROLL; u++) begin
            if (op_div) begin
                shifted = {nh, nl[WIDTH-1]};
                diff    = {1'b0, shifted} - {2'b00, operand};
                nl      = {nl[WIDTH-2:0], ~diff[WIDTH+1]};
                nh      = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            end else begin
                sum = {1'b0, nh} + (nl[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
                nl  = {sum[0], nl[WIDTH-1:1]};
                nh  = sum[WIDTH:1];
            end
        end
    end

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               fix_zero;

    always_comb begin
        prod_s   = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_s    = neg_q ? -acc_lo : acc_lo;
        rem_s    = neg_r ? -acc_hi : acc_hi;
        fix_hi   = op_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
        fix_lo   = op_div ? quo_s : prod_s[WIDTH-1:0];
        fix_zero = op_div ? (quo_s == '0) : (prod_s == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand   <= '0;
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
            flags     <= 3'b000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_mul || (is_div && rt_op != '0)) begin
                            state   <= S_CALC;
                            cnt     <= '0;
                            op_div  <= is_div;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            acc_hi  <= '0;
                            acc_lo  <= a_mag;
                            operand <= b_mag;
                        end else begin
                            out_valid <= 1'b1;
                            if (is_div) begin
                                result <= lo;
                                flags  <= 3'b001;
                            end else if (op_zero && funct == F_MFHI) begin
                                result <= hi;
                                flags  <= {hi == '0, hi[WIDTH-1], 1'b0};
                            end else if (op_zero && funct == F_MFLO) begin
                                result <= lo;
                                flags  <= {lo == '0, lo[WIDTH-1], 1'b0};
                            end else if (op_zero && funct == F_MTHI) begin
                                hi     <= rs_op;
                                result <= rs_op;
                                flags  <= {rs_op == '0, rs_op[WIDTH-1], 1'b0};
                            end else if (op_zero && funct == F_MTLO) begin
                                lo     <= rs_op;
                                result <= rs_op;
                                flags  <= {rs_op == '0, rs_op[WIDTH-1], 1'b0};
                            end else begin
                                result <= '0;
                                flags  <= 3'b000;
                            end
                        end
                    end
                end
                S_CALC: begin
                    acc_hi <= nh;
                    acc_lo <= nl;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    result    <= fix_lo;
                    flags     <= {fix_zero, fix_lo[WIDTH-1], 1'b0};
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{instruction[25:22], instruction[20:17], instruction[15:6], diff[WIDTH]};

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed-vector bench for alu_muldiv_iter: default build plus an UNROLL=4 build.
module tb_alu_muldiv_iter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_valid4;
    logic [31:0] instruction;
    logic [31:0] regA;
    logic [31:0] regB;

    logic        in_ready,  out_valid,  busy;
    logic [31:0] result,    hi,  lo;
    logic [2:0]  flags;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] result4,   hi4, lo4;
    logic [2:0]  flags4;

    int n_checks = 0;
    int n_fail   = 0;

    alu_muldiv_iter #(.WIDTH(32), .UNROLL(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .regA(regA), .regB(regB),
        .out_valid(out_valid), .result(result), .flags(flags), .busy(busy),
        .hi(hi), .lo(lo)
    );

    alu_muldiv_iter #(.WIDTH(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .instruction(instruction), .regA(regA), .regB(regB),
        .out_valid(out_valid4), .result(result4), .flags(flags4), .busy(busy4),
        .hi(hi4), .lo(lo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op on the chosen build and return cycles from accept edge to out_valid.
    task automatic run_op(input bit use4, input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        instruction = instr;
        regA        = a;
        regB        = b;
        if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        lat       = 1;
        while (!(use4 ? out_valid4 : out_valid) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    localparam logic [31:0] I_MULT  = 32'h0001_0018;
    localparam logic [31:0] I_MULTU = 32'h0001_0019;
    localparam logic [31:0] I_DIV   = 32'h0001_001A;
    localparam logic [31:0] I_DIVU  = 32'h0001_001B;
    localparam logic [31:0] I_MFHI  = 32'h0000_0010;
    localparam logic [31:0] I_MFLO  = 32'h0000_0012;
    localparam logic [31:0] I_MTHI  = 32'h0000_0011;
    localparam logic [31:0] I_MTLO  = 32'h0020_0013;

    initial begin
        int lat;
        int n;
        int stall_bad;
        int late;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_valid4   = 1'b0;
        instruction = '0;
        regA        = '0;
        regB        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        reset = 1'b0;

        run_op(0, I_MULT, 32'hFFFF_FFFD, 32'h0000_0007, lat);
        check("mult_lat", lat, 34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_result", result, 32'hFFFF_FFEB);
        check("mult_flags", flags, 3'b010);
        check("mult_in_ready", in_ready, 1);

        run_op(0, I_MULTU, 32'hFFFF_FFFD, 32'h0000_0007, lat);
        check("multu_lat", lat, 34);
        check("multu_hi", hi, 32'h0000_0006);
        check("multu_lo", lo, 32'hFFFF_FFEB);
        check("multu_flags", flags, 3'b010);

        run_op(0, I_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        check("div_lat", lat, 34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_flags", flags, 3'b010);

        run_op(0, I_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'h0000_0001);
        check("divu_flags", flags, 3'b000);

        run_op(0, I_DIV, 32'hFFFF_FFF9, 32'h0000_0000, lat);
        check("div0_lat", lat, 1);
        check("div0_flags", flags, 3'b001);
        check("div0_result", result, 32'h7FFF_FFFC);
        check("div0_hi", hi, 32'h0000_0001);
        check("div0_lo", lo, 32'h7FFF_FFFC);
        check("div0_in_ready", in_ready, 1);

        run_op(0, I_DIV, 32'h0000_0007, 32'hFFFF_FFFE, lat);
        check("div_negdiv_lo", lo, 32'hFFFF_FFFD);
        check("div_negdiv_hi", hi, 32'h0000_0001);

        run_op(0, I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_min_lo", lo, 32'h8000_0000);
        check("div_min_hi", hi, 32'h0000_0000);
        check("div_min_flags", flags, 3'b010);

        run_op(0, 32'h0001_0020, 32'h1234_5678, 32'h1, lat);
        check("bad_funct_lat", lat, 1);
        check("bad_funct_result", result, 0);
        check("bad_funct_flags", flags, 3'b000);
        check("bad_funct_lo", lo, 32'h8000_0000);

        run_op(0, 32'h2001_0018, 32'h1234_5678, 32'h5, lat);
        check("bad_opc_lat", lat, 1);
        check("bad_opc_result", result, 0);
        check("bad_opc_hi", hi, 32'h0000_0000);
        check("bad_opc_lo", lo, 32'h8000_0000);

        run_op(0, I_MULT, 32'h0000_0000, 32'h0000_0005, lat);
        check("mult_zero_lo", lo, 0);
        check("mult_zero_flags", flags, 3'b100);

        // mfhi held valid from 3 cycles after a mult accept.
        @(negedge clk);
        instruction = I_MULT;
        regA        = 32'h0001_0000;
        regB        = 32'h0003_0000;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        n = 2;
        @(negedge clk);
        n = 3;
        instruction = I_MFHI;
        in_valid    = 1'b1;
        stall_bad   = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) stall_bad++;
            @(negedge clk);
            n++;
        end
        check("stall_mult_lat", n, 34);
        check("stall_in_ready_low", stall_bad, 0);
        check("stall_mult_result", result, 32'h0000_0000);
        check("stall_mult_flags", flags, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_mfhi_valid", out_valid, 1);
        check("stall_mfhi_result", result, 32'h0000_0003);

        // Reset ten cycles into a divide.
        run_op(0, I_MULT, 32'h0000_0009, 32'h0000_0009, lat);
        check("pre_rst_lo", lo, 32'h0000_0051);
        @(negedge clk);
        instruction = I_DIV;
        regA        = 32'h0000_0064;
        regB        = 32'h0000_0003;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        late = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        check("abort_no_late_valid", late, 0);

        run_op(1, I_MULT, 32'h1234_5678, 32'h0000_0010, lat);
        check("u4_mult_lat", lat, 10);
        check("u4_mult_hi", hi4, 32'h0000_0001);
        check("u4_mult_lo", lo4, 32'h2345_6780);

        run_op(1, I_MTHI, 32'hCAFE_BABE, 32'h0BAD_F00D, lat);
        check("u4_mthi_result", result4, 32'hCAFE_BABE);
        run_op(1, I_MTLO, 32'hCAFE_BABE, 32'h0BAD_F00D, lat);
        check("u4_mtlo_result", result4, 32'h0BAD_F00D);
        run_op(1, I_MFHI, 32'h0, 32'h0, lat);
        check("u4_mfhi_lat", lat, 1);
        check("u4_mfhi_result", result4, 32'hCAFE_BABE);
        check("u4_mfhi_flags", flags4, 3'b010);
        run_op(1, I_MFLO, 32'h0, 32'h0, lat);
        check("u4_mflo_result", result4, 32'h0BAD_F00D);
        check("u4_mflo_flags", flags4, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
